// File: rtl/xram_arb.sv
// Two-master round-robin arbiter for the shared XRAM. It also has a no-ack watchdog
// and a sticky timeout flag for each master.
module xram_arb #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic        cpu_wr,
  input  logic        cpu_stb,
  output logic        cpu_ack,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_data_in,
  output logic [7:0]  dma_data_out,
  input  logic        dma_wr,
  input  logic        dma_stb,
  output logic        dma_ack,
  output logic [15:0] xram_addr,
  output logic [7:0]  xram_data_out,
  input  logic [7:0]  xram_data_in,
  output logic        xram_wr,
  output logic        xram_stb,
  input  logic        xram_ack,
  input  logic        err_clr,
  output logic [1:0]  tmo_err
);

  // state   | meaning
  // IDLE    | no grant; XRAM outputs held at zero
  // GNT_CPU | CPU owns the XRAM
  // GNT_DMA | copy engine owns the XRAM
  typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]  tmo_err_q, tmo_err_d;

  logic granted, g_stb, tmo_fire, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      wait_cnt_q <= 16'h0000;
      tmo_err_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  always_comb begin
    granted  = (state_q == GNT_CPU) || (state_q == GNT_DMA);
    g_stb    = ((state_q == GNT_CPU) && cpu_stb) || ((state_q == GNT_DMA) && dma_stb);
    // An ack or abort only counts while the owner is still strobing.
    tmo_fire = (TIMEOUT != 16'd0) && g_stb && !xram_ack &&
               (wait_cnt_q == TIMEOUT - 16'd1);
    done     = g_stb && (xram_ack || tmo_fire);

    state_d       = state_q;
    last_d        = last_q;
    tmo_err_d     = err_clr ? 2'b00 : tmo_err_q;
    wait_cnt_d    = 16'h0000;
    xram_addr     = 16'h0000;
    xram_data_out = 8'h00;
    xram_wr       = 1'b0;
    xram_stb      = 1'b0;
    cpu_ack       = 1'b0;
    cpu_data_out  = 8'h00;
    dma_ack       = 1'b0;
    dma_data_out  = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (cpu_stb && (!dma_stb || last_q)) state_d = GNT_CPU;
        else if (dma_stb)                    state_d = GNT_DMA;
      end
      GNT_CPU: begin
        xram_addr     = cpu_addr;
        xram_data_out = cpu_data_in;
        xram_wr       = cpu_wr;
        xram_stb      = cpu_stb && !tmo_fire;
        cpu_ack       = done;
        cpu_data_out  = tmo_fire ? 8'h00 : xram_data_in;
        if (done) begin
          last_d = 1'b0;
          if (tmo_fire) tmo_err_d[0] = 1'b1;
          if (dma_stb)       state_d = GNT_DMA;
          else if (!cpu_stb) state_d = IDLE;
        end else if (!cpu_stb) begin
          state_d = IDLE;
        end
      end
      GNT_DMA: begin
        xram_addr     = dma_addr;
        xram_data_out = dma_data_in;
        xram_wr       = dma_wr;
        xram_stb      = dma_stb && !tmo_fire;
        dma_ack       = done;
        dma_data_out  = tmo_fire ? 8'h00 : xram_data_in;
        if (done) begin
          last_d = 1'b1;
          if (tmo_fire) tmo_err_d[1] = 1'b1;
          if (cpu_stb)       state_d = GNT_CPU;
          else if (!dma_stb) state_d = IDLE;
        end else if (!dma_stb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (granted && !done && (state_d == state_q)) wait_cnt_d = wait_cnt_q + 16'd1;
  end

  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_xram_arb.sv
// Directed bench for xram_arb. Expected values are written out by hand, and each
// one is checked with an immediate assertion.
module tb_xram_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = '0, dma_addr = '0;
  logic [7:0]  cpu_data_in = '0, dma_data_in = '0, xram_data_in = '0;
  logic        cpu_wr = 1'b0, cpu_stb = 1'b0, dma_wr = 1'b0, dma_stb = 1'b0;
  logic        xram_ack = 1'b0, err_clr = 1'b0;
  logic [7:0]  cpu_data_out, dma_data_out, xram_data_out;
  logic        cpu_ack, dma_ack, xram_wr, xram_stb;
  logic [15:0] xram_addr;
  logic [1:0]  tmo_err;

  int n_cmp = 0;
  int n_err = 0;

  xram_arb #(.TIMEOUT(16'd4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .cpu_wr(cpu_wr), .cpu_stb(cpu_stb), .cpu_ack(cpu_ack),
    .dma_addr(dma_addr), .dma_data_in(dma_data_in), .dma_data_out(dma_data_out),
    .dma_wr(dma_wr), .dma_stb(dma_stb), .dma_ack(dma_ack),
    .xram_addr(xram_addr), .xram_data_out(xram_data_out), .xram_data_in(xram_data_in),
    .xram_wr(xram_wr), .xram_stb(xram_stb), .xram_ack(xram_ack),
    .err_clr(err_clr), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    cyc(); cyc();
    mid();
    chk("rst_xram_stb", 16'(xram_stb), 16'h0);
    chk("rst_xram_addr", xram_addr, 16'h0);
    chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
    chk("rst_tmo_err", 16'(tmo_err), 16'h0);
    cyc(); rst = 1'b0;

    // CPU read: grant arrives one cycle late, and the XRAM acks one cycle after its strobe
    cyc();
    cpu_stb = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0123; xram_data_in = 8'h5A;
    mid();
    chk("rd_stb_idle", 16'(xram_stb), 16'h0);
    cyc(); mid();
    chk("rd_stb_gnt", 16'(xram_stb), 16'h1);
    chk("rd_addr", xram_addr, 16'h0123);
    chk("rd_ack_wait", 16'(cpu_ack), 16'h0);
    cyc(); xram_ack = 1'b1;
    mid();
    chk("rd_cpu_ack", 16'(cpu_ack), 16'h1);
    chk("rd_cpu_data", 16'(cpu_data_out), 16'h005A);
    chk("rd_dma_ack", 16'(dma_ack), 16'h0);
    cyc(); cpu_stb = 1'b0; xram_ack = 1'b0;
    mid();
    chk("rd_drop_stb", 16'(xram_stb), 16'h0);
    cyc();

    // Tie from reset: CPU goes first, then the two masters alternate
    rst = 1'b1; cyc(); rst = 1'b0;
    cpu_addr = 16'h1111; dma_addr = 16'h2222; cpu_stb = 1'b1; dma_stb = 1'b1; xram_ack = 1'b1;
    mid();
    chk("tie_idle", 16'(xram_stb), 16'h0);
    cyc();
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("tie_addr", xram_addr, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      chk("tie_cpu_ack", 16'(cpu_ack), (i % 2 == 0) ? 16'h1 : 16'h0);
      chk("tie_dma_ack", 16'(dma_ack), (i % 2 == 0) ? 16'h0 : 16'h1);
      cyc();
    end
    cpu_stb = 1'b0; dma_stb = 1'b0; xram_ack = 1'b0;
    cyc(); cyc();

    // Copy-engine burst: 16 back-to-back writes
    dma_stb = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0000; dma_data_in = 8'hA0; xram_ack = 1'b1;
    cyc();
    for (int k = 0; k < 16; k++) begin
      mid();
      chk("bst_dma_ack", 16'(dma_ack), 16'h1);
      chk("bst_wr", 16'(xram_wr), 16'h1);
      chk("bst_addr", xram_addr, 16'(k));
      chk("bst_data", 16'(xram_data_out), 16'(8'hA0 + 8'(k)));
      cyc();
      dma_addr = 16'(k + 1); dma_data_in = 8'hA0 + 8'(k + 1);
    end
    dma_stb = 1'b0; dma_wr = 1'b0; xram_ack = 1'b0;
    cyc(); cyc();

    // Watchdog with TIMEOUT=4: the XRAM never acks
    cpu_stb = 1'b1; cpu_addr = 16'h0040; xram_data_in = 8'h5A;
    cyc();
    for (int j = 1; j <= 4; j++) begin
      mid();
      chk("wd_cpu_ack", 16'(cpu_ack), (j == 4) ? 16'h1 : 16'h0);
      if (j == 4) begin
        chk("wd_data", 16'(cpu_data_out), 16'h0);
        chk("wd_xram_stb", 16'(xram_stb), 16'h0);
        chk("wd_err_pre", 16'(tmo_err), 16'h0);
      end
      cyc();
    end
    cpu_stb = 1'b0;
    mid();
    chk("wd_err_set", 16'(tmo_err), 16'h1);
    cyc(); err_clr = 1'b1;
    cyc(); err_clr = 1'b0;
    mid();
    chk("wd_err_clr", 16'(tmo_err), 16'h0);
    cyc();

    // Abandon: the copy engine drops its strobe while a CPU request is pending
    dma_stb = 1'b1; dma_addr = 16'h3333; cpu_addr = 16'h4444;
    cyc(); mid();
    chk("ab_gnt", 16'(xram_stb), 16'h1);
    cyc(); dma_stb = 1'b0; cpu_stb = 1'b1;
    mid();
    chk("ab_stb_drop", 16'(xram_stb), 16'h0);
    chk("ab_dma_ack", 16'(dma_ack), 16'h0);
    cyc(); mid();
    chk("ab_idle_stb", 16'(xram_stb), 16'h0);
    chk("ab_idle_addr", xram_addr, 16'h0);
    cyc(); mid();
    chk("ab_cpu_gnt", 16'(xram_stb), 16'h1);
    chk("ab_cpu_addr", xram_addr, 16'h4444);
    cyc(); cpu_stb = 1'b0;
    cyc(); cyc();

    // Reset while GNT_DMA, with a timeout flag already set
    dma_stb = 1'b1; dma_addr = 16'h5555;
    cyc();
    for (int j = 1; j <= 4; j++) begin
      mid();
      chk("rm_dma_ack", 16'(dma_ack), (j == 4) ? 16'h1 : 16'h0);
      cyc();
    end
    chk("rm_err_set", 16'(tmo_err), 16'h2);
    chk("rm_stb_pre", 16'(xram_stb), 16'h1);
    #1 rst = 1'b1;
    #1;
    chk("rm_xram_stb", 16'(xram_stb), 16'h0);
    chk("rm_dma_ack0", 16'(dma_ack), 16'h0);
    chk("rm_tmo_err", 16'(tmo_err), 16'h0);
    cyc(); cpu_stb = 1'b1; cpu_addr = 16'h6666; xram_ack = 1'b1;
    rst = 1'b0;
    cyc(); mid();
    chk("rm_tie_addr", xram_addr, 16'h6666);
    chk("rm_tie_cpu_ack", 16'(cpu_ack), 16'h1);
    chk("rm_tie_dma_ack", 16'(dma_ack), 16'h0);
    cyc(); cpu_stb = 1'b0; dma_stb = 1'b0; xram_ack = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
